// File: rtl/adc_capture_buffer.sv
// Multi-channel ADC capture engine: offset-binary to two's complement, boxcar
// decimation and a pre/post-trigger window per channel in circular memory.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no capture in progress, memory frozen
// PRE   | filling the pre-trigger history, triggers ignored
// ARMED | writing and watching for threshold or forced trigger
// POST  | writing the remainder of the window after the trigger
// DONE  | window complete and frozen, readable until re-armed
module adc_capture_buffer #(
   parameter int NCH        = 4,
   parameter int ADC_W      = 12,
   parameter int OUT_W      = 16,
   parameter int DECIM_LOG2 = 2,
   parameter int DEPTH_LOG2 = 10,
   parameter int PRE        = 256,
   localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                    wrclk,
   input  logic                    rst,
   input  logic [NCH*ADC_W-1:0]    din,
   input  logic                    din_valid,
   input  logic                    arm,
   input  logic                    force_trig,
   input  logic [OUT_W-1:0]        thresh,
   input  logic                    rd_en,
   input  logic [CH_W-1:0]         rd_ch,
   input  logic [DEPTH_LOG2-1:0]   rd_idx,
   output logic [OUT_W-1:0]        rd_data,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    done,
   output logic [CH_W-1:0]         trig_ch,
   output logic                    trig_forced
);

   localparam int AW     = ADC_W + DECIM_LOG2;
   localparam int PH_W   = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int POST_N = DEPTH - PRE - 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_ARMED = 3'd2;
   localparam logic [2:0] S_POST  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [OUT_W-1:0] MOST_NEG = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] MAX_POS  = ~MOST_NEG;

   logic [PH_W-1:0]         phase_q, phase_d;
   logic signed [AW-1:0]    acc_q [NCH];
   logic signed [AW-1:0]    acc_d [NCH];
   logic signed [OUT_W-1:0] dec_q [NCH];
   logic signed [OUT_W-1:0] dec_d [NCH];
   logic                    dec_valid_q, dec_valid_d;

   logic [2:0]              state_q, state_d;
   logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0]   base_q, base_d;
   logic [CH_W-1:0]         trig_ch_q, trig_ch_d;
   logic                    trig_forced_q, trig_forced_d;
   logic [OUT_W-1:0]        rd_data_q, rd_data_d;
   logic                    rd_valid_q, rd_valid_d;

   logic [OUT_W-1:0]        mem_q [NCH][DEPTH];

   logic                    wr;
   logic                    thr_any;
   logic [CH_W-1:0]         thr_ch;
   logic                    rd_ch_ok;
   logic [DEPTH_LOG2-1:0]   rd_addr;

   // Decimator: the first sample of a block replaces the accumulator, the last
   // one produces the floored average.
   always_comb begin
      logic                    phase_last;
      logic [ADC_W-1:0]        raw;
      logic signed [ADC_W-1:0] conv;
      logic signed [AW-1:0]    x;
      logic signed [AW-1:0]    sum;
      logic signed [ADC_W-1:0] q;
      phase_d     = phase_q;
      dec_valid_d = 1'b0;
      phase_last  = (DECIM_LOG2 == 0) || (phase_q == '1);
      raw         = '0;
      conv        = '0;
      x           = '0;
      sum         = '0;
      q           = '0;
      for (int k = 0; k < NCH; k++) begin
         acc_d[k] = acc_q[k];
         dec_d[k] = dec_q[k];
      end
      if (din_valid) begin
         phase_d = phase_last ? '0 : phase_q + 1'b1;
         for (int k = 0; k < NCH; k++) begin
            raw  = din[k*ADC_W +: ADC_W];
            conv = {~raw[ADC_W-1], raw[ADC_W-2:0]};
            x    = conv;
            sum  = (phase_q == '0) ? x : acc_q[k] + x;
            acc_d[k] = sum;
            if (phase_last) begin
               q        = ADC_W'(sum >>> DECIM_LOG2);
               dec_d[k] = q;
            end
         end
         dec_valid_d = phase_last;
      end
   end

   // Threshold detect on the sample currently being written; lowest channel wins.
   always_comb begin
      logic [OUT_W-1:0] mag;
      thr_any = 1'b0;
      thr_ch  = '0;
      mag     = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (OUT_W'(dec_q[k]) == MOST_NEG) begin
            mag = MAX_POS;
         end else if (dec_q[k][OUT_W-1]) begin
            mag = -dec_q[k];
         end else begin
            mag = dec_q[k];
         end
         if (mag >= thresh) begin
            thr_any = 1'b1;
            thr_ch  = CH_W'(k);
         end
      end
   end

   assign wr = dec_valid_q && !rst &&
               (state_q == S_PRE || state_q == S_ARMED || state_q == S_POST);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wptr_d        = wptr_q;
      base_d        = base_q;
      trig_ch_d     = trig_ch_q;
      trig_forced_d = trig_forced_q;
      if (wr) begin
         wptr_d = wptr_q + 1'b1;
      end
      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm) begin
               state_d = S_PRE;
               cnt_d   = '0;
            end
         end
         S_PRE: begin
            if (wr) begin
               if (cnt_q == DEPTH_LOG2'(PRE - 1)) begin
                  state_d = S_ARMED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_ARMED: begin
            if (wr && (thr_any || force_trig)) begin
               base_d        = wptr_q - DEPTH_LOG2'(PRE);
               trig_ch_d     = thr_any ? thr_ch : '0;
               trig_forced_d = !thr_any;
               cnt_d         = '0;
               state_d       = (POST_N == 0) ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            if (wr) begin
               if (cnt_q == DEPTH_LOG2'(POST_N - 1)) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Channels beyond NCH exist only in the rd_ch encoding and read back as zero.
   assign rd_ch_ok = (32'(rd_ch) < NCH);
   assign rd_addr  = base_q + rd_idx;

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_en;
      if (rd_en) begin
         rd_data_d = rd_ch_ok ? mem_q[rd_ch][rd_addr] : '0;
      end
   end

   always_ff @(posedge wrclk) begin
      if (rst) begin
         phase_q       <= '0;
         dec_valid_q   <= 1'b0;
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         wptr_q        <= '0;
         base_q        <= '0;
         trig_ch_q     <= '0;
         trig_forced_q <= 1'b0;
         rd_data_q     <= '0;
         rd_valid_q    <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            acc_q[k] <= '0;
            dec_q[k] <= '0;
         end
      end else begin
         phase_q       <= phase_d;
         dec_valid_q   <= dec_valid_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wptr_q        <= wptr_d;
         base_q        <= base_d;
         trig_ch_q     <= trig_ch_d;
         trig_forced_q <= trig_forced_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         for (int k = 0; k < NCH; k++) begin
            acc_q[k] <= acc_d[k];
            dec_q[k] <= dec_d[k];
         end
      end
   end

   // Sample memory has no reset; contents are only meaningful in DONE.
   always_ff @(posedge wrclk) begin
      if (wr) begin
         for (int k = 0; k < NCH; k++) begin
            mem_q[k][wptr_q] <= dec_q[k];
         end
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign busy        = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
   assign done        = (state_q == S_DONE);
   assign trig_ch     = trig_ch_q;
   assign trig_forced = trig_forced_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer: drives decimation blocks, models the written
// history per channel and scoreboards readback against the expected window.
module tb_adc_capture_buffer;
   localparam int NCH = 4, ADC_W = 12, OUT_W = 16, DL = 2, DLOG = 4, PRE = 4;
   localparam int DEPTH = 16;

   logic                  wrclk = 1'b0;
   logic                  rst = 1'b1;
   logic [NCH*ADC_W-1:0]  din = '0;
   logic                  din_valid = 1'b0;
   logic                  arm = 1'b0;
   logic                  force_trig = 1'b0;
   logic [OUT_W-1:0]      thresh = '1;
   logic                  rd_en = 1'b0;
   logic [1:0]            rd_ch = '0;
   logic [DLOG-1:0]       rd_idx = '0;
   logic [OUT_W-1:0]      rd_data;
   logic                  rd_valid;
   logic                  busy;
   logic                  done;
   logic [1:0]            trig_ch;
   logic                  trig_forced;

   int              n_chk = 0;
   int              n_err = 0;
   logic [15:0]     exp_q [$];
   logic [15:0]     exp_v;
   int              hist [NCH][$];

   adc_capture_buffer #(
      .NCH(NCH), .ADC_W(ADC_W), .OUT_W(OUT_W), .DECIM_LOG2(DL),
      .DEPTH_LOG2(DLOG), .PRE(PRE)
   ) dut (
      .wrclk(wrclk), .rst(rst), .din(din), .din_valid(din_valid), .arm(arm),
      .force_trig(force_trig), .thresh(thresh), .rd_en(rd_en), .rd_ch(rd_ch),
      .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .done(done), .trig_ch(trig_ch), .trig_forced(trig_forced)
   );

   always #5 wrclk = ~wrclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] pack(input int v0, input int v1, input int v2, input int v3);
      logic [11:0] a0, a1, a2, a3;
      a0 = 12'(v0 + 2048);
      a1 = 12'(v1 + 2048);
      a2 = 12'(v2 + 2048);
      a3 = 12'(v3 + 2048);
      return {a3, a2, a1, a0};
   endfunction

   // One decimation block of four valid samples, then settle so the write and
   // any state change have happened when the task returns.
   task automatic feed_dec(input logic [47:0] r0, input logic [47:0] r1,
                           input logic [47:0] r2, input logic [47:0] r3);
      logic [47:0] rs [4];
      int          sum;
      rs[0] = r0; rs[1] = r1; rs[2] = r2; rs[3] = r3;
      for (int j = 0; j < 4; j++) begin
         @(negedge wrclk);
         din       = rs[j];
         din_valid = 1'b1;
      end
      @(negedge wrclk);
      din_valid = 1'b0;
      @(negedge wrclk);
      for (int k = 0; k < NCH; k++) begin
         sum = 0;
         for (int j = 0; j < 4; j++) sum += int'(rs[j][k*12 +: 12]) - 2048;
         hist[k].push_back(sum >>> 2);
      end
   endtask

   task automatic feed_vals(input int v0, input int v1, input int v2, input int v3);
      logic [47:0] r;
      r = pack(v0, v1, v2, v3);
      feed_dec(r, r, r, r);
   endtask

   task automatic feed_rand();
      feed_vals(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
   endtask

   task automatic do_arm();
      @(negedge wrclk);
      arm = 1'b1;
      for (int k = 0; k < NCH; k++) hist[k].delete();
      @(negedge wrclk);
      arm = 1'b0;
   endtask

   task automatic read_one(input int ch, input int idx, input logic [15:0] e);
      @(negedge wrclk);
      rd_en  = 1'b1;
      rd_ch  = 2'(ch);
      rd_idx = 4'(idx);
      exp_q.push_back(e);
      @(negedge wrclk);
      rd_en = 1'b0;
   endtask

   // Back-to-back reads of the whole window; the window is the last DEPTH writes.
   task automatic read_window(input int ch);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge wrclk);
         rd_en  = 1'b1;
         rd_ch  = 2'(ch);
         rd_idx = 4'(i);
         exp_q.push_back(16'(hist[ch][hist[ch].size() - DEPTH + i]));
      end
      @(negedge wrclk);
      rd_en = 1'b0;
      @(negedge wrclk);
   endtask

   always @(negedge wrclk) begin
      if (!rst && rd_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("rd_spurious", 32'd1, 32'd0);
         end else begin
            exp_v = exp_q.pop_front();
            check_eq("rd_data", 32'(rd_data), 32'(exp_v));
         end
      end
   end

   initial begin
      logic [47:0] all_f, all_0;
      all_f = pack(2047, 2047, 2047, 2047);
      all_0 = pack(-2048, -2048, -2048, -2048);

      repeat (3) @(negedge wrclk);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_trig_ch", 32'(trig_ch), 0);
      check_eq("rst_trig_forced", 32'(trig_forced), 0);
      check_eq("rst_rd_valid", 32'(rd_valid), 0);
      check_eq("rst_rd_data", 32'(rd_data), 0);
      rst = 1'b0;

      // Capture 1: decimator patterns in PRE, force held from the start.
      thresh = '1;
      force_trig = 1'b1;
      do_arm();
      check_eq("c1_busy", 32'(busy), 1);
      feed_vals(0, 0, 0, 0);
      feed_vals(2047, 2047, 2047, 2047);
      feed_vals(-2048, -2048, -2048, -2048);
      feed_dec(all_f, all_f, all_0, all_0);
      check_eq("c1_pre_ignores_force", 32'(trig_forced), 0);
      feed_rand();
      force_trig = 1'b0;
      check_eq("c1_trig_forced", 32'(trig_forced), 1);
      check_eq("c1_trig_ch", 32'(trig_ch), 0);
      repeat (10) feed_rand();
      check_eq("c1_done_early", 32'(done), 0);
      feed_rand();
      check_eq("c1_done", 32'(done), 1);
      check_eq("c1_busy_end", 32'(busy), 0);
      read_one(0, 0, 16'h0000);
      read_one(1, 1, 16'h07FF);
      read_one(2, 2, 16'hF800);
      read_one(3, 3, 16'hFFFF);
      read_window(3);

      // Capture 2: ramp on ch2, threshold trigger at exactly 10.
      thresh = 16'd10;
      do_arm();
      check_eq("c2_rearm_clears_done", 32'(done), 0);
      check_eq("c2_busy", 32'(busy), 1);
      for (int v = 1; v <= 9; v++) feed_vals(0, 0, v, 0);
      check_eq("c2_no_early_trig", 32'(trig_forced), 1);
      feed_vals(0, 0, 10, 0);
      check_eq("c2_trig_ch", 32'(trig_ch), 2);
      check_eq("c2_trig_forced", 32'(trig_forced), 0);
      for (int v = 11; v <= 20; v++) feed_vals(0, 0, v, 0);
      check_eq("c2_done_early", 32'(done), 0);
      feed_vals(0, 0, 21, 0);
      check_eq("c2_done", 32'(done), 1);
      read_one(2, 4, 16'd10);
      read_one(2, 0, 16'd6);
      read_window(2);

      // Capture 3: arm while busy is ignored, reset mid-POST discards everything.
      thresh = '1;
      force_trig = 1'b1;
      do_arm();
      feed_rand();
      feed_rand();
      @(negedge wrclk);
      arm = 1'b1;
      @(negedge wrclk);
      arm = 1'b0;
      feed_rand();
      feed_rand();
      check_eq("c3_pre_holds", 32'(trig_forced), 0);
      feed_rand();
      check_eq("c3_arm_ignored", 32'(trig_forced), 1);
      check_eq("c3_busy_post", 32'(busy), 1);
      force_trig = 1'b0;
      feed_rand();
      feed_rand();
      @(negedge wrclk);
      rst = 1'b1;
      arm = 1'b1;
      @(negedge wrclk);
      rst = 1'b0;
      arm = 1'b0;
      check_eq("c3_rst_busy", 32'(busy), 0);
      check_eq("c3_rst_done", 32'(done), 0);
      check_eq("c3_rst_trig_forced", 32'(trig_forced), 0);
      @(negedge wrclk);
      check_eq("c3_stays_idle", 32'(busy), 0);

      // Capture 4: force after 7 untriggered ARMED samples, window wraps.
      thresh = '1;
      do_arm();
      repeat (4) feed_rand();
      repeat (7) feed_rand();
      check_eq("c4_no_trig", 32'(trig_forced), 0);
      force_trig = 1'b1;
      feed_rand();
      force_trig = 1'b0;
      check_eq("c4_trig_forced", 32'(trig_forced), 1);
      check_eq("c4_trig_ch", 32'(trig_ch), 0);
      repeat (11) feed_rand();
      check_eq("c4_done", 32'(done), 1);
      for (int k = 0; k < NCH; k++) read_window(k);

      // Capture 5: negative magnitude, lowest channel, threshold beats force.
      thresh = 16'd100;
      do_arm();
      repeat (6) feed_vals(0, 0, 0, 0);
      force_trig = 1'b1;
      feed_vals(99, -150, 0, 500);
      force_trig = 1'b0;
      check_eq("c5_trig_ch", 32'(trig_ch), 1);
      check_eq("c5_trig_forced", 32'(trig_forced), 0);
      repeat (11) feed_vals(0, 0, 0, 0);
      check_eq("c5_done", 32'(done), 1);
      read_one(1, 4, 16'hFF6A);
      read_one(3, 4, 16'h01F4);
      read_one(0, 4, 16'h0063);
      read_window(1);

      repeat (3) @(negedge wrclk);
      check_eq("rd_pending", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Parametrised multi-channel ADC capture engine: converts offset-binary ADC words to two's complement, boxcar-decimates every channel, and records a pre/post-trigger window per channel into on-chip circular memory. Generalises the fixed quad decimate-and-forward path to NCH channels with threshold/forced triggering and a random-access readout port for the Blackfin bus block. Sits between the ADC capture pins and the bus interface, entirely in the ADC clock domain.

## Interface
- NCH, 4: channel count (1-8)
- ADC_W, 12: raw ADC sample width, offset binary
- OUT_W, 16: stored sample width, two's complement (OUT_W >= ADC_W)
- DECIM_LOG2, 2: decimation factor is 2^DECIM_LOG2 (0 = bypass)
- DEPTH_LOG2, 10: per-channel buffer depth is 2^DEPTH_LOG2 samples
- PRE, 256: pre-trigger samples kept (1 <= PRE < 2^DEPTH_LOG2)

- wrclk  in  1  sole clock (ADC clock)
- rst  in  1  synchronous, active-high reset
- din  in  NCH*ADC_W  raw samples, channel k at [k*ADC_W +: ADC_W]
- din_valid  in  1  din sample strobe, all channels together
- arm  in  1  pulse: start a new capture
- force_trig  in  1  level: trigger regardless of threshold
- thresh  in  OUT_W  unsigned magnitude threshold
- rd_en  in  1  read request
- rd_ch  in  clog2(NCH) (min 1)  read channel
- rd_idx  in  DEPTH_LOG2  read index relative to window start
- rd_data  out  OUT_W  read data
- rd_valid  out  1  rd_data valid strobe
- busy  out  1  state is PRE, ARMED or POST
- done  out  1  window captured, level
- trig_ch  out  clog2(NCH)  channel that triggered
- trig_forced  out  1  trigger came from force_trig

## Operation
- Conversion: x = {~d[ADC_W-1], d[ADC_W-2:0]} as signed, sign-extended to ADC_W+DECIM_LOG2.
- Decimator: shared phase counter advances on each din_valid; per channel accumulator sums 2^DECIM_LOG2 samples; on the last one, dec = acc >>> DECIM_LOG2 (arithmetic, floor), sign-extended to OUT_W, dec_valid pulses. Accumulators restart at next sample. Phase reset only by rst.
- Memory: NCH x 2^DEPTH_LOG2 x OUT_W; all channels written at wptr on dec_valid in PRE/ARMED/POST; wptr wraps modulo depth. Memory is not cleared by rst.
- States:
  - IDLE: no writes. arm -> PRE (cnt=0, done=0).
  - PRE: write; cnt++; on write with cnt==PRE-1 -> ARMED. Triggers ignored.
  - ARMED: write; trigger if force_trig, or any channel |dec| >= thresh (|most negative| saturates to max positive). On trigger: base = wptr-PRE (mod depth), trig_ch = lowest exceeding channel (0 and trig_forced=1 if only forced; threshold hit takes precedence when both), cnt=0 -> POST.
  - POST: write; after 2^DEPTH_LOG2-PRE-1 further writes -> DONE (if that count is 0, go straight to DONE).
  - DONE: done=1, no writes; arm -> PRE.
- arm outside IDLE/DONE ignored. rst overrides arm.
- Read: rd_data = mem[rd_ch][(base+rd_idx) mod depth]. rd_idx=PRE is the trigger sample, 0 oldest pre-trigger. Reads legal in any state; content only meaningful in DONE. rd_ch >= NCH returns 0.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, done=0, trig_ch=0, trig_forced=0, state IDLE, wptr=0, base=0, phase=0, accumulators 0.
- din_valid -> dec_valid/write: dec registered 1 cycle after final contributing din_valid; written same cycle it is valid.
- Trigger evaluated on the sample being written; state changes next cycle.
- done and busy=0 assert the cycle after the last POST write.
- Read latency 1: rd_data/rd_valid valid the cycle after rd_en; rd_valid=0 otherwise, rd_data holds last value.
- rst mid-capture: IDLE next cycle, captured window discarded (done=0).

## Test plan
- NCH=4, ADC_W=12, DECIM_LOG2=2, DEPTH_LOG2=4, PRE=4. Constant din 0x800 on all channels, 4 valids -> dec=0; 0xFFF -> +2047; 0x000 -> -2048; mixed 0xFFF,0xFFF,0x000,0x000 -> -1 (floor).
- Arm, ramp samples 1..N on ch2, thresh=10, others 0 -> trigger on first ARMED sample >= 10, trig_ch=2, done after 11 more writes; rd_idx 4 returns 10, rd_idx 0..3 the 4 preceding values.
- thresh above all data, force_trig after 7 ARMED samples -> trig_forced=1, trig_ch=0; window contains 16 contiguous samples across wptr wrap.
- force_trig held high during PRE -> ignored until 4 pre-samples written; trigger on 5th sample.
- rst during POST -> busy=0, done=0 next cycle; arm during busy ignored; re-arm from DONE clears done.
- Read pipelining: rd_en on consecutive cycles with idx 0..15 -> 16 back-to-back rd_valid, correct order; rd_ch=4 (when NCH=5 test build absent) returns 0.
